// File: rtl/ldpc_enc_ctrl.sv
// rtl/ldpc_enc_ctrl.sv - LDPC encoder frame controller: buffers BEATS 27-bit words, bursts them to the encoder, waits LAT cycles, then holds the codeword for the sink.
// Optional macro LDPC_ENC_CTRL_PREFILL_EN: accept the next frame during WAIT/HOLD.
module ldpc_enc_ctrl #(
  parameter int BEATS = 6,
  parameter int LAT   = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [26:0]  s_data,
  output logic         enc_valid,
  output logic [26:0]  enc_data,
  input  logic [161:0] enc_cw,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [161:0] m_data,
  output logic         busy
);

`ifdef LDPC_ENC_CTRL_PREFILL_EN
  localparam bit PREFILL = 1'b1;
`else
  localparam bit PREFILL = 1'b0;
`endif

  localparam int              CW       = $clog2(BEATS + 1);
  localparam logic [CW-1:0]   BEATS_C  = CW'(BEATS);
  localparam logic [CW-1:0]   LAST_C   = CW'(BEATS - 1);
  localparam logic [7:0]      LAT_LAST = 8'(LAT - 1);

  typedef enum logic [1:0] {FILL, BURST, WAIT, HOLD} state_t;

  state_t        state;
  logic [26:0]   buffer [BEATS];
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [7:0]    wt_cnt;

  logic          acc;
  logic [CW-1:0] wr_cnt_inc;
  logic          full_nx;
  logic [26:0]   first_word;
  logic [26:0]   next_word;

  assign acc        = s_valid && s_ready;
  assign wr_cnt_inc = wr_cnt + CW'(acc);
  assign full_nx    = (wr_cnt_inc == BEATS_C);
  // With a one-word frame the first beat is the word being accepted right now
  assign first_word = (acc && (wr_cnt == '0)) ? s_data : buffer[0];
  assign next_word  = buffer[rd_cnt + 1'b1];

  // Message buffer write; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (acc) buffer[wr_cnt] <= s_data;
  end

  // Frame sequencing FSM with registered handshake and encoder outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      wt_cnt    <= '0;
      s_ready   <= 1'b1;
      enc_valid <= 1'b0;
      enc_data  <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      busy      <= 1'b0;
    end else begin
      wr_cnt <= wr_cnt_inc;
      case (state)
        FILL: begin
          if (acc) busy <= 1'b1;
          if (full_nx) begin
            state     <= BURST;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            s_ready   <= 1'b0;
            enc_valid <= 1'b1;
            enc_data  <= first_word;
          end
        end
        BURST: begin
          if (rd_cnt == LAST_C) begin
            state     <= WAIT;
            wt_cnt    <= '0;
            enc_valid <= 1'b0;
            enc_data  <= '0;
            s_ready   <= PREFILL;
          end else begin
            rd_cnt   <= rd_cnt + 1'b1;
            enc_data <= next_word;
          end
        end
        WAIT: begin
          if (full_nx) s_ready <= 1'b0;
          if (wt_cnt == LAT_LAST) begin
            state   <= HOLD;
            m_data  <= enc_cw;
            m_valid <= 1'b1;
          end else begin
            wt_cnt <= wt_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (full_nx) s_ready <= 1'b0;
          if (m_ready) begin
            m_valid <= 1'b0;
            if (full_nx) begin
              // A complete next frame is already buffered: go straight to the encoder
              state     <= BURST;
              wr_cnt    <= '0;
              rd_cnt    <= '0;
              s_ready   <= 1'b0;
              enc_valid <= 1'b1;
              enc_data  <= first_word;
            end else begin
              state   <= FILL;
              s_ready <= 1'b1;
              busy    <= (wr_cnt_inc != '0);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/ldpc_enc_ctrl.md
LDPC_ENC_CTRL -- requirements
Module: ldpc_enc_ctrl

Interface
REQ-001 SHALL have parameter BEATS, default 6: number of 27-bit message words per frame, legal range 1..63.
REQ-002 SHALL have parameter LAT, default 10: cycles from the first enc_valid-low cycle to a stable enc_cw, legal range 1..255.
REQ-003 SHALL have port clk, input, 1: clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port s_valid, input, 1: message word valid.
REQ-006 SHALL have port s_ready, output, 1: word accepted when s_valid&&s_ready.
REQ-007 SHALL have port s_data, input, 27: message word.
REQ-008 SHALL have port enc_valid, output, 1: encoder accumulate strobe.
REQ-009 SHALL have port enc_data, output, 27: word presented to encoder.
REQ-010 SHALL have port enc_cw, input, 162: encoder codeword {p1,p2}.
REQ-011 SHALL have port m_valid, output, 1: codeword valid.
REQ-012 SHALL have port m_ready, input, 1: downstream accept.
REQ-013 SHALL have port m_data, output, 162: registered codeword.
REQ-014 SHALL have port busy, output, 1: high unless state FILL with zero words buffered.

Function
REQ-015 SHALL keep a BEATS x 27 word buffer, a write counter wr_cnt, a read counter rd_cnt, and a wait counter wt_cnt.
REQ-016 SHALL implement states FILL, BURST, WAIT, HOLD; reset state FILL.
REQ-017 FILL: s_ready=1; each accepted word goes to buffer[wr_cnt] and wr_cnt increments; on the accept that makes wr_cnt==BEATS -> BURST next cycle, wr_cnt cleared.
REQ-018 BURST: enc_valid=1 for exactly BEATS consecutive cycles with enc_data=buffer[rd_cnt], rd_cnt 0..BEATS-1; after the last beat -> WAIT; enc_valid SHALL never drop mid-burst.
REQ-019 Outside BURST, enc_valid=0 and enc_data=0.
REQ-020 WAIT: wt_cnt counts LAT cycles; in the LAT-th cycle m_data<=enc_cw; -> HOLD.
REQ-021 HOLD: m_valid=1; m_data stable until m_valid&&m_ready; on that cycle m_valid drops next cycle.
REQ-022 HOLD exit -> BURST if a full frame is buffered (REQ-034), else FILL.
REQ-023 Latency: last word accepted in cycle c -> enc_valid high c+1..c+BEATS -> m_valid high from c+BEATS+LAT+1.
REQ-024 m_valid SHALL never be deasserted without handshake; s_data ignored when s_ready=0.
REQ-025 Back-to-back: m_ready held high -> next frame FILL starts the cycle after handshake; no word lost or duplicated.

Reset
REQ-026 rst low SHALL asynchronously force state FILL, all counters 0, s_ready=1 after release, enc_valid=0, enc_data=0, m_valid=0, m_data=0, busy=0.
REQ-027 Reset mid-BURST or mid-WAIT SHALL abort the frame; no m_valid pulse for the aborted frame after release.
REQ-028 Buffer contents need no reset; partially filled frames are discarded by wr_cnt clear.

Configuration
REQ-029 Macro LDPC_ENC_CTRL_PREFILL_EN selects prefill of the next frame.
REQ-030 Without it: s_ready=1 only in FILL.
REQ-031 With it: s_ready=1 also in WAIT and HOLD while wr_cnt<BEATS; accepted words fill the buffer (safe, burst already read out).
REQ-032 With it, s_ready=0 in BURST.
REQ-033 With it, when the buffer becomes full during WAIT/HOLD, s_ready drops until BURST completes.
REQ-034 With it, HOLD exit with wr_cnt==BEATS goes directly to BURST; without it the full-buffer path is unreachable.

Verification (BEATS=6, LAT=10)
REQ-035 Single frame: 6 words 0x1..0x6 in cycles 0..5, m_ready=1 -> enc_valid cycles 6..11 with enc_data 0x1..0x6; m_valid cycle 22 with m_data=enc_cw sampled cycle 21.
REQ-036 Backpressure: m_ready=0 for 20 cycles after m_valid -> m_data unchanged, s_ready=0 (macro off), one handshake only.
REQ-037 Gapped input: s_valid toggling every other cycle -> enc_valid still 6 contiguous cycles with correct word order.
REQ-038 Reset at cycle 8 of REQ-035 stimulus -> all outputs 0 immediately; no m_valid in following 30 cycles; next frame encodes correctly.
REQ-039 Macro on: second frame streamed during WAIT -> second burst begins cycle after first m_valid handshake; macro off -> s_ready=0 in WAIT.
REQ-040 Idle: s_valid=0 for 100 cycles after reset -> busy=0, enc_valid=0, m_valid=0 throughout.
